// File: rtl/urv_mem_pkg.sv
// urv_mem_pkg: shared types and sizing helpers for the uRV dual-port RAM
package urv_mem_pkg;
  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam int C_BYTE_W = 8;
  localparam int C_DEF_LANES = 32 / C_BYTE_W;
  localparam int C_DEF_IDX_W = 16 - 2;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/urv_dpram_clear_seq.sv
// urv_dpram_clear_seq: post-reset zero-fill sequencer; owns ready
module urv_dpram_clear_seq
  import urv_mem_pkg::*;
#(
  parameter int g_depth = 16,
  parameter int g_idx_w = 4,
  parameter int g_clear_on_reset = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic               ready_o,
  output logic               clear_we_o,
  output logic [g_idx_w-1:0] clear_addr_o
);
  localparam logic CLR = g_clear_on_reset != 0;
  state_t state_q, state_d;
  logic [g_idx_w-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, last;
  assign last = cnt_q == g_idx_w'(g_depth - 1);
  always_comb begin
    state_d = (state_q == S_CLEAR && last) ? S_READY : state_q;
    cnt_d = (state_q == S_CLEAR && !last) ? cnt_q + 1'b1 : cnt_q;
    ready_d = state_d == S_READY;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLR ? S_CLEAR : S_READY;
      cnt_q <= '0;
      ready_q <= !CLR;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
    end
  end
  assign ready_o = ready_q;
  assign clear_we_o = state_q == S_CLEAR;
  assign clear_addr_o = cnt_q;
endmodule

// File: rtl/urv_dpram.sv
// urv_dpram: true dual-port byte-writable RAM, read-first, port A wins write collisions.
// URV_DPRAM_OUTREG_EN adds an output register stage (read latency 2).
module urv_dpram
  import urv_mem_pkg::*;
#(
  parameter int g_size = 65536,
  parameter int g_data_width = 32,
  parameter int g_clear_on_reset = 1,
  parameter g_init_file = "",
  parameter int g_simulation = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  output logic                      ready_o,
  input  logic                      ena_i,
  input  logic                      wea_i,
  input  logic [31:0]               aa_i,
  input  logic [g_data_width/8-1:0] bwea_i,
  input  logic [g_data_width-1:0]   da_i,
  output logic [g_data_width-1:0]   qa_o,
  output logic                      qa_valid_o,
  input  logic                      enb_i,
  input  logic                      web_i,
  input  logic [31:0]               ab_i,
  input  logic [g_data_width/8-1:0] bweb_i,
  input  logic [g_data_width-1:0]   db_i,
  output logic [g_data_width-1:0]   qb_o,
  output logic                      qb_valid_o,
  output logic                      coll_o
);
  localparam int LANES = g_data_width / C_BYTE_W;
  localparam int AW = clog2(g_size);
  localparam int BO = clog2(LANES);
  localparam int IW = AW - BO;
  localparam int DEPTH = 1 << IW;
  localparam int unused_cfg = g_simulation + $bits(g_init_file);
  logic [g_data_width-1:0] mem [DEPTH];
  logic [IW-1:0] idx_a, idx_b, clear_addr;
  logic ready, clear_we, acc_a, acc_b, wr_a, wr_b, unused_addr;
  logic [g_data_width-1:0] qa_d, qa_q, qb_d, qb_q;
  logic va_d, va_q, vb_d, vb_q, coll_d, coll_q;
  urv_dpram_clear_seq #(
    .g_depth(DEPTH), .g_idx_w(IW), .g_clear_on_reset(g_clear_on_reset)
  ) u_clear (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ready_o(ready),
    .clear_we_o(clear_we), .clear_addr_o(clear_addr)
  );
  assign unused_addr = ^{aa_i, ab_i};
  assign idx_a = aa_i[AW-1:BO];
  assign idx_b = ab_i[AW-1:BO];
  always_comb begin
    acc_a = ena_i & ready;
    acc_b = enb_i & ready;
    wr_a = acc_a & wea_i;
    wr_b = acc_b & web_i;
    va_d = acc_a;
    vb_d = acc_b;
    qa_d = acc_a ? mem[idx_a] : qa_q;
    qb_d = acc_b ? mem[idx_b] : qb_q;
    coll_d = acc_a & acc_b & (idx_a == idx_b) & (wea_i | web_i);
  end
  // B lanes are written first so A's overlapping lanes take precedence
  always_ff @(posedge clk_i) begin
    if (clear_we) mem[clear_addr] <= '0;
    for (int k = 0; k < LANES; k++)
      if (wr_b && bweb_i[k]) mem[idx_b][8*k +: 8] <= db_i[8*k +: 8];
    for (int k = 0; k < LANES; k++)
      if (wr_a && bwea_i[k]) mem[idx_a][8*k +: 8] <= da_i[8*k +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      qa_q <= '0;
      qb_q <= '0;
      va_q <= 1'b0;
      vb_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
      va_q <= va_d;
      vb_q <= vb_d;
      coll_q <= coll_d;
    end
  end
  assign ready_o = ready;
  assign coll_o = coll_q;
`ifdef URV_DPRAM_OUTREG_EN
  logic [g_data_width-1:0] qa2_q, qb2_q;
  logic va2_q, vb2_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      qa2_q <= '0;
      qb2_q <= '0;
      va2_q <= 1'b0;
      vb2_q <= 1'b0;
    end else begin
      qa2_q <= qa_q;
      qb2_q <= qb_q;
      va2_q <= va_q;
      vb2_q <= vb_q;
    end
  end
  assign qa_o = qa2_q;
  assign qb_o = qb2_q;
  assign qa_valid_o = va2_q;
  assign qb_valid_o = vb2_q;
`else
  assign qa_o = qa_q;
  assign qb_o = qb_q;
  assign qa_valid_o = va_q;
  assign qb_valid_o = vb_q;
`endif
endmodule

// File: tb/tb_urv_dpram.sv
// tb_urv_dpram: directed checks of urv_dpram with g_size=64 (16 words of 32 bits)
module tb_urv_dpram;
`ifdef URV_DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst_n = 1, ena = 0, wea = 0, enb = 0, web = 0;
  logic [31:0] aa = 0, ab = 0, da = 0, db = 0, qa, qb;
  logic [3:0] bwea = 0, bweb = 0;
  logic ready, qav, qbv, coll;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  urv_dpram #(.g_size(64), .g_data_width(32), .g_clear_on_reset(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ready_o(ready),
    .ena_i(ena), .wea_i(wea), .aa_i(aa), .bwea_i(bwea), .da_i(da), .qa_o(qa), .qa_valid_o(qav),
    .enb_i(enb), .web_i(web), .ab_i(ab), .bweb_i(bweb), .db_i(db), .qb_o(qb), .qb_valid_o(qbv),
    .coll_o(coll)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic a_en, a_we, input logic [31:0] a_ad, input logic [3:0] a_be,
                       input logic [31:0] a_d, input logic b_en, b_we, input logic [31:0] b_ad,
                       input logic [3:0] b_be, input logic [31:0] b_d);
    ena = a_en; wea = a_we; aa = a_ad; bwea = a_be; da = a_d;
    enb = b_en; web = b_we; ab = b_ad; bweb = b_be; db = b_d;
  endtask
  task automatic idle;
    ena = 0; enb = 0; wea = 0; web = 0;
  endtask
  task automatic access_a(input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] d);
    drive(1, we, ad, be, d, 0, 0, 0, 0, 0);
    step;
    idle;
    repeat (LAT - 1) step;
  endtask
  task automatic access_b(input logic we, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] d);
    drive(0, 0, 0, 0, 0, 1, we, ad, be, d);
    step;
    idle;
    repeat (LAT - 1) step;
  endtask
  task automatic test_reset;
    int n;
    #3 rst_n = 0;
    #1;
    vecs++; if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b expected 0", ready); end
    vecs++; if ({qa, qb, qav, qbv, coll} !== '0) begin errs++; $display("FAIL reset_outs: got %h %h %b%b%b expected all 0", qa, qb, qav, qbv, coll); end
    step; step;
    rst_n = 1;
    n = 0;
    while (!ready && n < 64) begin step; n++; end
    vecs++; if (n != 16) begin errs++; $display("FAIL clear_cycles: got %0d expected 16", n); end
  endtask
  task automatic test_clear_zero;
    for (int i = 0; i < 16; i++) begin
      access_a(0, 32'(i * 4), 4'h0, 0);
      vecs++; if (qa !== 32'h0 || qav !== 1'b1) begin errs++; $display("FAIL clear_word%0d: got %h/%b expected 00000000/1", i, qa, qav); end
    end
  endtask
  task automatic test_byte_write;
    access_a(1, 32'h10, 4'hF, 32'h11223344);
    access_a(1, 32'h10, 4'b0101, 32'hDEADBEEF);
    vecs++; if (qa !== 32'h11223344 || qav !== 1'b1) begin errs++; $display("FAIL write_read_first: got %h/%b expected 11223344/1", qa, qav); end
    access_a(0, 32'h10, 4'h0, 0);
    vecs++; if (qa !== 32'h11AD33EF) begin errs++; $display("FAIL byte_merge: got %h expected 11ad33ef", qa); end
  endtask
  task automatic test_port_b;
    access_b(1, 32'h14, 4'hF, 32'hCAFEF00D);
    vecs++; if (qb !== 32'h0 || qbv !== 1'b1) begin errs++; $display("FAIL b_read_first: got %h/%b expected 00000000/1", qb, qbv); end
    access_b(0, 32'h14, 4'h0, 0);
    vecs++; if (qb !== 32'hCAFEF00D) begin errs++; $display("FAIL b_read: got %h expected cafef00d", qb); end
    step;
    vecs++; if (qbv !== 1'b0 || qb !== 32'hCAFEF00D) begin errs++; $display("FAIL b_hold: got %h/%b expected cafef00d/0", qb, qbv); end
  endtask
  task automatic test_collision;
    access_a(1, 32'h0C, 4'hF, 32'hBB000000);
    drive(1, 1, 32'h0C, 4'b0011, 32'hAAAAAAAA, 1, 1, 32'h0C, 4'b0110, 32'hBBBBBBBB);
    step;
    vecs++; if (coll !== 1'b1) begin errs++; $display("FAIL coll_set: got %b expected 1", coll); end
    idle;
    step;
    vecs++; if (coll !== 1'b0) begin errs++; $display("FAIL coll_clear: got %b expected 0", coll); end
    access_a(0, 32'h0C, 4'h0, 0);
    vecs++; if (qa !== 32'hBBBBAAAA) begin errs++; $display("FAIL coll_merge: got %h expected bbbbaaaa", qa); end
    drive(1, 0, 32'h0C, 4'h0, 0, 1, 0, 32'h0C, 4'h0, 0);
    step;
    vecs++; if (coll !== 1'b0) begin errs++; $display("FAIL coll_readread: got %b expected 0", coll); end
    idle;
    repeat (LAT) step;
  endtask
  task automatic test_cross_port;
    access_a(1, 32'h20, 4'hF, 32'h11111111);
    drive(1, 0, 32'h20, 4'h0, 0, 1, 1, 32'h20, 4'hF, 32'h5);
    step;
    vecs++; if (coll !== 1'b1) begin errs++; $display("FAIL cross_coll: got %b expected 1", coll); end
    idle;
    repeat (LAT - 1) step;
    vecs++; if (qa !== 32'h11111111 || qav !== 1'b1) begin errs++; $display("FAIL cross_old: got %h/%b expected 11111111/1", qa, qav); end
    vecs++; if (qb !== 32'h11111111) begin errs++; $display("FAIL cross_b_old: got %h expected 11111111", qb); end
    access_a(0, 32'h60, 4'h0, 0);
    vecs++; if (qa !== 32'h5) begin errs++; $display("FAIL alias_read: got %h expected 00000005", qa); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] ad [4] = '{32'h10, 32'h0C, 32'h20, 32'h14};
    logic [31:0] ex [4] = '{32'h11AD33EF, 32'hBBBBAAAA, 32'h5, 32'hCAFEF00D};
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      if (i < 4) drive(1, 0, ad[i], 4'h0, 0, 0, 0, 0, 0, 0); else idle;
      step;
      if (i - LAT + 1 >= 0) begin
        vecs++;
        if (qa !== ex[i-LAT+1] || qav !== 1'b1) begin errs++; $display("FAIL stream%0d: got %h/%b expected %h/1", i - LAT + 1, qa, qav, ex[i-LAT+1]); end
      end
    end
    idle;
    step;
  endtask
  task automatic test_reset_mid_clear;
    int n, bad;
    rst_n = 0;
    #1;
    vecs++; if (qa !== 32'h0 || ready !== 1'b0) begin errs++; $display("FAIL async_reset: got %h/%b expected 00000000/0", qa, ready); end
    step;
    rst_n = 1;
    repeat (7) step;
    rst_n = 0;
    #1;
    vecs++; if (ready !== 1'b0 || qav !== 1'b0) begin errs++; $display("FAIL mid_reset: got %b/%b expected 0/0", ready, qav); end
    step;
    rst_n = 1;
    drive(1, 0, 32'h4, 4'h0, 0, 1, 1, 32'h0, 4'hF, 32'hFFFFFFFF);
    n = 0;
    bad = 0;
    while (!ready && n < 64) begin
      step;
      n++;
      if (qav || qbv) bad++;
    end
    idle;
    vecs++; if (n != 16) begin errs++; $display("FAIL restart_cycles: got %0d expected 16", n); end
    vecs++; if (bad != 0) begin errs++; $display("FAIL clear_valid: got %0d valid cycles expected 0", bad); end
    access_a(0, 32'h0, 4'h0, 0);
    vecs++; if (qa !== 32'h0) begin errs++; $display("FAIL clear_drop_write: got %h expected 00000000", qa); end
    access_a(0, 32'h20, 4'h0, 0);
    vecs++; if (qa !== 32'h0) begin errs++; $display("FAIL restart_full: got %h expected 00000000", qa); end
  endtask
  initial begin
    test_reset;
    test_clear_zero;
    test_byte_write;
    test_port_b;
    test_collision;
    test_cross_port;
    test_back_to_back;
    test_reset_mid_clear;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
